// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch_timer block.
//
// Contents:
//   DIGIT_W / COUNTER_W  - output widths of one decimal digit and of the ms total
//   MS_WRAP              - length of one full display cycle (100 minutes) in ms
//   DEC_MAX / SEK_ZEHNER_MAX - highest value each digit type shows before wrapping
//   IDX_*                - bit positions of the raw inputs inside the synchronizer vector
package stopwatch_pkg;

    localparam int DIGIT_W        = 8;
    localparam int COUNTER_W      = 32;
    localparam int MS_WRAP        = 6_000_000;

    localparam int DEC_MAX        = 9;
    localparam int SEK_ZEHNER_MAX = 5;

    // All asynchronous inputs travel through one shared synchronizer vector.
    // sw0..sw7 occupy bits 0..7 so the switch index equals the bit index.
    localparam int IDX_SW0   = 0;
    localparam int IDX_BTN   = 8;
    localparam int IDX_1HZ   = 9;
    localparam int IDX_10HZ  = 10;
    localparam int IDX_100HZ = 11;
    localparam int IDX_1KHZ  = 12;
    localparam int N_IN      = 13;

endpackage

// File: rtl/bcd_digit_counter.sv
// One decimal display digit with clear and carry.
//
// Ports:
//   clk, reset_n - system clock, asynchronous active-low reset
//   clr          - synchronous clear, wins over inc
//   inc          - advance the digit by one this cycle
//   digit        - registered digit value 0..MAX, binary, upper bits 0
//   carry        - inc && digit==MAX; feeds inc of the next more significant digit
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DEC_MAX
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry
);

    logic [DIGIT_W-1:0] digit_q;
    logic [DIGIT_W-1:0] digit_d;
    logic               at_max;

    assign at_max = (digit_q == DIGIT_W'(MAX));

    // Carry is combinational so the whole chain ripples within one cycle.
    assign carry = inc && at_max;
    assign digit = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = at_max ? '0 : digit_q + DIGIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/stopwatch_timer.sv
// Millisecond stopwatch (mm:ss.fff) driven by a 1 kHz tick.
//
// Ports:
//   clk, reset_n           - 50 MHz system clock, asynchronous active-low reset
//   clk_1kHz               - rising edge = one millisecond (advances time while running)
//   clk_100Hz              - accepted and synchronized, otherwise unused
//   clk_10Hz               - run blink source for led0
//   clk_1Hz                - heartbeat source for led8
//   user_button            - rising edge toggles run/stop (debounced upstream)
//   sw7..sw1               - mirrored to led7..led1
//   sw0                    - level clear, holds the time at zero while high
//   led8..led0             - heartbeat, switch mirror, run blink
//   min_zehner..sek_tausendstel - decimal digits 0..9 (sek_zehner 0..5)
//   counter                - elapsed ms since last clear, always equal to the digits
//
// Every input passes SYNC_STAGES flops and then one edge register, so an input
// change reaches the outputs exactly SYNC_STAGES+1 clock cycles later.
// SYNC_STAGES must be at least 2.
module stopwatch_timer
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clk_1kHz,
    input  logic                 clk_100Hz,
    input  logic                 clk_10Hz,
    input  logic                 clk_1Hz,
    input  logic                 user_button,
    input  logic                 sw7,
    input  logic                 sw6,
    input  logic                 sw5,
    input  logic                 sw4,
    input  logic                 sw3,
    input  logic                 sw2,
    input  logic                 sw1,
    input  logic                 sw0,
    output logic                 led8,
    output logic                 led7,
    output logic                 led6,
    output logic                 led5,
    output logic                 led4,
    output logic                 led3,
    output logic                 led2,
    output logic                 led1,
    output logic                 led0,
    output logic [DIGIT_W-1:0]   min_zehner,
    output logic [DIGIT_W-1:0]   min_einer,
    output logic [DIGIT_W-1:0]   sek_zehner,
    output logic [DIGIT_W-1:0]   sek_einer,
    output logic [DIGIT_W-1:0]   sek_zehntel,
    output logic [DIGIT_W-1:0]   sek_hundertstel,
    output logic [DIGIT_W-1:0]   sek_tausendstel,
    output logic [COUNTER_W-1:0] counter
);

    // ------------------------------------------------------------------
    // Input synchronizer and edge register
    // ------------------------------------------------------------------
    logic [N_IN-1:0]                  async_in;
    logic [SYNC_STAGES-1:0][N_IN-1:0] sync_q;
    logic [N_IN-1:0]                  sync_s;
    logic [N_IN-1:0]                  edge_q;

    assign async_in = {clk_1kHz, clk_100Hz, clk_10Hz, clk_1Hz, user_button,
                       sw7, sw6, sw5, sw4, sw3, sw2, sw1, sw0};
    assign sync_s   = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            edge_q <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            edge_q <= sync_s;
        end
    end

    logic tick_rise;
    logic btn_rise;
    logic clr;

    assign tick_rise = sync_s[IDX_1KHZ] & ~edge_q[IDX_1KHZ];
    assign btn_rise  = sync_s[IDX_BTN]  & ~edge_q[IDX_BTN];
    assign clr       = sync_s[IDX_SW0];

    // ------------------------------------------------------------------
    // Run state, run blink and millisecond total
    // ------------------------------------------------------------------
    logic                 running_q, running_d;
    logic                 led0_q, led0_d;
    logic [COUNTER_W-1:0] counter_q, counter_d;
    logic                 advance;

    // A tick in the same cycle as a button edge uses the old run state.
    assign advance = tick_rise & running_q;

    always_comb begin
        running_d = running_q ^ btn_rise;
        // Uses the new run state so the blink lines up with the toggle.
        led0_d    = running_d & sync_s[IDX_10HZ];
        counter_d = counter_q;
        if (clr) begin
            counter_d = '0;
        end else if (advance) begin
            counter_d = (counter_q == COUNTER_W'(MS_WRAP - 1)) ? '0
                                                               : counter_q + COUNTER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running_q <= 1'b0;
            led0_q    <= 1'b0;
            counter_q <= '0;
        end else begin
            running_q <= running_d;
            led0_q    <= led0_d;
            counter_q <= counter_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit chain, least significant first, linked by carry
    // ------------------------------------------------------------------
    logic c_taus, c_hund, c_zehntel, c_sek_e, c_sek_z, c_min_e, c_min_z;

    bcd_digit_counter #(.MAX(DEC_MAX)) u_sek_tausendstel (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(advance),
        .digit(sek_tausendstel), .carry(c_taus)
    );

    bcd_digit_counter #(.MAX(DEC_MAX)) u_sek_hundertstel (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(c_taus),
        .digit(sek_hundertstel), .carry(c_hund)
    );

    bcd_digit_counter #(.MAX(DEC_MAX)) u_sek_zehntel (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(c_hund),
        .digit(sek_zehntel), .carry(c_zehntel)
    );

    bcd_digit_counter #(.MAX(DEC_MAX)) u_sek_einer (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(c_zehntel),
        .digit(sek_einer), .carry(c_sek_e)
    );

    bcd_digit_counter #(.MAX(SEK_ZEHNER_MAX)) u_sek_zehner (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(c_sek_e),
        .digit(sek_zehner), .carry(c_sek_z)
    );

    bcd_digit_counter #(.MAX(DEC_MAX)) u_min_einer (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(c_sek_z),
        .digit(min_einer), .carry(c_min_e)
    );

    bcd_digit_counter #(.MAX(DEC_MAX)) u_min_zehner (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(c_min_e),
        .digit(min_zehner), .carry(c_min_z)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign counter = counter_q;
    assign led8    = edge_q[IDX_1HZ];
    assign led7    = edge_q[7];
    assign led6    = edge_q[6];
    assign led5    = edge_q[5];
    assign led4    = edge_q[4];
    assign led3    = edge_q[3];
    assign led2    = edge_q[2];
    assign led1    = edge_q[1];
    assign led0    = led0_q;

    // Registered copies that no output needs; the 100 Hz input is accepted only.
    logic unused_ok;
    assign unused_ok = ^{edge_q[IDX_SW0], edge_q[IDX_10HZ], edge_q[IDX_100HZ], c_min_z};

endmodule

// File: tb/tb_stopwatch_timer.sv
module tb_stopwatch_timer;
    import stopwatch_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clk_1kHz = 1'b0, clk_100Hz = 1'b0, clk_10Hz = 1'b0, clk_1Hz = 1'b0;
    logic user_button = 1'b0;
    logic sw7 = 1'b0, sw6 = 1'b0, sw5 = 1'b0, sw4 = 1'b0;
    logic sw3 = 1'b0, sw2 = 1'b0, sw1 = 1'b0, sw0 = 1'b0;
    logic led8, led7, led6, led5, led4, led3, led2, led1, led0;
    logic [7:0]  min_zehner, min_einer, sek_zehner, sek_einer;
    logic [7:0]  sek_zehntel, sek_hundertstel, sek_tausendstel;
    logic [31:0] counter;

    always #5 clk = ~clk;

    stopwatch_timer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .clk_1kHz(clk_1kHz), .clk_100Hz(clk_100Hz), .clk_10Hz(clk_10Hz), .clk_1Hz(clk_1Hz),
        .user_button(user_button),
        .sw7(sw7), .sw6(sw6), .sw5(sw5), .sw4(sw4), .sw3(sw3), .sw2(sw2), .sw1(sw1), .sw0(sw0),
        .led8(led8), .led7(led7), .led6(led6), .led5(led5), .led4(led4),
        .led3(led3), .led2(led2), .led1(led1), .led0(led0),
        .min_zehner(min_zehner), .min_einer(min_einer), .sek_zehner(sek_zehner),
        .sek_einer(sek_einer), .sek_zehntel(sek_zehntel),
        .sek_hundertstel(sek_hundertstel), .sek_tausendstel(sek_tausendstel),
        .counter(counter)
    );

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard state and bench model
    // ------------------------------------------------------------------
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];
    int          model_ms = 0;
    bit          running_m = 1'b0;

    logic [31:0] pl_cnt;
    logic [7:0]  pl_mz, pl_me, pl_sz, pl_se, pl_zt, pl_hu, pl_ta;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pops the oldest expected elapsed time and compares every time output.
    task automatic check_state(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".tausendstel"}, 32'(sek_tausendstel), e % 10);
        check({tag, ".hundertstel"}, 32'(sek_hundertstel), (e / 10) % 10);
        check({tag, ".zehntel"},     32'(sek_zehntel),     (e / 100) % 10);
        check({tag, ".sek_einer"},   32'(sek_einer),       (e / 1000) % 10);
        check({tag, ".sek_zehner"},  32'(sek_zehner),      (e / 10000) % 6);
        check({tag, ".min_einer"},   32'(min_einer),       (e / 60000) % 10);
        check({tag, ".min_zehner"},  32'(min_zehner),      (e / 600000) % 10);
        check({tag, ".counter"},     counter,              e);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_tick();
        clk_1kHz = 1'b1;
        cyc(2);
        clk_1kHz = 1'b0;
        cyc(2);
        if (sw0) model_ms = 0;
        else if (running_m) model_ms = (model_ms + 1) % MS_WRAP;
    endtask

    task automatic do_press();
        user_button = 1'b1;
        cyc(4);
        user_button = 1'b0;
        cyc(4);
        running_m = !running_m;
    endtask

    // Loads a time directly into the registers to reach the far corners fast.
    task automatic preload(input int ms);
        pl_cnt = 32'(ms);
        pl_ta  = 8'(ms % 10);
        pl_hu  = 8'((ms / 10) % 10);
        pl_zt  = 8'((ms / 100) % 10);
        pl_se  = 8'((ms / 1000) % 10);
        pl_sz  = 8'((ms / 10000) % 6);
        pl_me  = 8'((ms / 60000) % 10);
        pl_mz  = 8'((ms / 600000) % 10);
        force dut.counter_q = pl_cnt;
        force dut.u_sek_tausendstel.digit_q = pl_ta;
        force dut.u_sek_hundertstel.digit_q = pl_hu;
        force dut.u_sek_zehntel.digit_q = pl_zt;
        force dut.u_sek_einer.digit_q = pl_se;
        force dut.u_sek_zehner.digit_q = pl_sz;
        force dut.u_min_einer.digit_q = pl_me;
        force dut.u_min_zehner.digit_q = pl_mz;
        cyc(1);
        release dut.counter_q;
        release dut.u_sek_tausendstel.digit_q;
        release dut.u_sek_hundertstel.digit_q;
        release dut.u_sek_zehntel.digit_q;
        release dut.u_sek_einer.digit_q;
        release dut.u_sek_zehner.digit_q;
        release dut.u_min_einer.digit_q;
        release dut.u_min_zehner.digit_q;
        cyc(1);
        model_ms = ms;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        int ticks;
        bit press;
        int exp_ms;
    } step_t;

    step_t steps[6];

    initial begin
        steps[0] = '{20,  1'b0, 0};     // idle after reset: no counting
        steps[1] = '{10,  1'b1, 10};    // start, 10 ms
        steps[2] = '{989, 1'b0, 999};
        steps[3] = '{1,   1'b0, 1000};  // carry into sek_einer
        steps[4] = '{50,  1'b1, 1000};  // stopped: frozen
        steps[5] = '{7,   1'b1, 1007};  // resumed from held value

        // Reset state, with switches high to show the LEDs stay dark.
        {sw7, sw6, sw5, sw4, sw3, sw2, sw1} = 7'h7f;
        cyc(3);
        exp_q.push_back(32'd0);
        check_state("reset");
        check("reset.leds", 32'({led8, led7, led6, led5, led4, led3, led2, led1, led0}), 32'd0);
        {sw7, sw6, sw5, sw4, sw3, sw2, sw1} = 7'h00;
        reset_n = 1'b1;
        cyc(4);

        for (int i = 0; i < 6; i++) begin
            if (steps[i].press) do_press();
            repeat (steps[i].ticks) do_tick();
            exp_q.push_back(32'(steps[i].exp_ms));
            check_state($sformatf("step%0d", i));
        end
        check("step0.led0_idle", 32'(led0), 32'd0);

        // Run blink and heartbeat lag (running now).
        clk_10Hz = 1'b1;
        cyc(2);
        check("led0.lag2", 32'(led0), 32'd0);
        cyc(1);
        check("led0.lag3", 32'(led0), 32'd1);
        clk_10Hz = 1'b0;
        cyc(3);
        check("led0.fall", 32'(led0), 32'd0);
        clk_1Hz = 1'b1;
        cyc(2);
        check("led8.lag2", 32'(led8), 32'd0);
        cyc(1);
        check("led8.lag3", 32'(led8), 32'd1);
        clk_1Hz = 1'b0;
        cyc(3);
        check("led8.fall", 32'(led8), 32'd0);

        // Switch mirror.
        {sw7, sw6, sw5, sw4, sw3, sw2, sw1} = 7'b1010101;
        cyc(2);
        check("sw_leds.lag2", 32'({led7, led6, led5, led4, led3, led2, led1}), 32'd0);
        cyc(1);
        check("sw_leds.lag3", 32'({led7, led6, led5, led4, led3, led2, led1}), 32'b1010101);

        // Tick-to-output latency.
        clk_1kHz = 1'b1;
        cyc(2);
        check("tick.lag2", counter, 32'(model_ms));
        cyc(1);
        check("tick.lag3", counter, 32'(model_ms + 1));
        clk_1kHz = 1'b0;
        cyc(2);
        model_ms = model_ms + 1;

        // Clear arriving together with a tick: clear wins.
        sw0 = 1'b1;
        clk_1kHz = 1'b1;
        cyc(3);
        exp_q.push_back(32'd0);
        check_state("clr_tick");
        clk_1kHz = 1'b0;
        cyc(2);
        model_ms = 0;
        repeat (3) do_tick();
        exp_q.push_back(32'(model_ms));
        check_state("clr_hold");
        sw0 = 1'b0;
        cyc(4);
        repeat (5) do_tick();
        exp_q.push_back(32'(model_ms));
        check("clr_resume.counter", counter, 32'd5);
        check_state("clr_resume");

        // Minute carry.
        preload(59_998);
        do_tick();
        exp_q.push_back(32'(model_ms));
        check_state("pre_min");
        do_tick();
        exp_q.push_back(32'(model_ms));
        check("min_carry.counter", counter, 32'd60000);
        check_state("min_carry");

        // Full wrap at 99:59.999.
        preload(5_999_998);
        do_tick();
        exp_q.push_back(32'(model_ms));
        check("pre_wrap.counter", counter, 32'd5999999);
        check_state("pre_wrap");
        do_tick();
        exp_q.push_back(32'(model_ms));
        check("wrap.counter", counter, 32'd0);
        check_state("wrap");
        do_tick();
        exp_q.push_back(32'(model_ms));
        check_state("post_wrap");
        clk_10Hz = 1'b1;
        cyc(3);
        check("wrap.still_running", 32'(led0), 32'd1);

        // Reset in the middle of a run.
        reset_n = 1'b0;
        #1;
        running_m = 1'b0;
        model_ms = 0;
        exp_q.push_back(32'd0);
        check_state("run_reset");
        check("run_reset.leds", 32'({led8, led7, led6, led5, led4, led3, led2, led1, led0}), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(4);
        repeat (5) do_tick();
        exp_q.push_back(32'(model_ms));
        check_state("after_reset_stopped");
        check("after_reset.led0", 32'(led0), 32'd0);
        do_press();
        repeat (3) do_tick();
        exp_q.push_back(32'(model_ms));
        check("after_reset_run.counter", counter, 32'd3);
        check_state("after_reset_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer.md
Name: stopwatch_timer

Overview:
Millisecond stopwatch for the MAX1000 board application layer. Counts elapsed time in mm:ss.fff from a 1 kHz tick while running and exposes each decimal digit plus a binary millisecond total. It is started and stopped by the user button, cleared by a switch, and reports status on LEDs. Tick inputs come from the board prescaler and are sampled as data in the single system clock domain.

Parameters:
SYNC_STAGES, 2, flip-flop stages on every asynchronous input (tick clocks, button, switches); minimum 2.

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
clk_1kHz  in  1  1 kHz tick square wave; rising edge = one millisecond
clk_100Hz  in  1  100 Hz square wave; accepted, unused
clk_10Hz  in  1  10 Hz square wave; drives the run blink
clk_1Hz  in  1  1 Hz square wave; drives the heartbeat
user_button  in  1  rising edge toggles run/stop
sw7..sw1  in  1 each  mirrored to led7..led1
sw0  in  1  level-sensitive clear (high = hold time at zero)
led8  out  1  heartbeat = synchronized clk_1Hz
led7..led1  out  1 each  synchronized sw7..sw1
led0  out  1  running ? synchronized clk_10Hz : 0
min_zehner, min_einer, sek_zehner, sek_einer, sek_zehntel, sek_hundertstel, sek_tausendstel  out  8 each  digit value 0..9, binary, upper bits 0
counter  out  32  elapsed milliseconds since last clear, binary

Behaviour:
- Reset (reset_n=0, asynchronous): all digits 0, counter 0, running 0, every LED 0, synchronizer and edge registers 0.
- All inputs pass through SYNC_STAGES flops, then one edge register. A rising edge is detected when the synchronized value is 1 and the edge register is 0.
- Input edge to visible output change is exactly SYNC_STAGES+1 clk cycles; 3 cycles by default.
- user_button edge toggles running. No debounce is required; the board debounces upstream.
- ms tick is the clk_1kHz rising edge. It advances time only when running=1, using the pre-toggle value of running in the same cycle.
- Advance: tausendstel increments. Carries ripple in the same cycle:
  - tausendstel, hundertstel, zehntel, sek_einer and min_einer wrap 9 to 0.
  - sek_zehner wraps 5 to 0.
  - min_zehner wraps 9 to 0.
- counter increments by 1 on each advance.
- Full wrap: 99:59.999 plus one tick gives all digits 0 and counter 0. counter therefore stays within 0..5_999_999 and always equals the digits converted to milliseconds.
- Clear (synchronized sw0=1): all digits and counter forced to 0 every cycle. Clear has priority over a simultaneous tick. running is not altered, so counting resumes from 0 when sw0 is released.
- Stop: the time holds its value, and toggling running again resumes from the held value.
- Outputs are registered. Digits and counter update in the same cycle.
- Reset during a run returns the block to the stopped state at zero.

Decomposition:
- Shared package stopwatch_pkg holds:
  - DIGIT_W=8, COUNTER_W=32, MS_WRAP=6_000_000
  - digit limits: 9 for decimal digits, 5 for sek_zehner
- One natural sub-module, bcd_digit_counter:
  - parameter MAX
  - inputs: clk, reset_n, clr, inc
  - outputs: digit[7:0] and carry, where carry = inc && digit==MAX
  - Seven instances are cascaded by carry.

Test Plan:
- Reset, then 20 ticks with no button press -> all digits 0, counter 0, led0=0.
- Pulse user_button, then 10 ticks -> hundertstel=1, tausendstel=0, counter=10. led0 follows clk_10Hz and led8 follows clk_1Hz, each with a 3-cycle lag.
- Run to counter=999, then one tick -> sek_einer=1, zehntel=hundertstel=tausendstel=0, counter=1000.
- Run to 00:59.999, then one tick -> min_einer=1, sek_zehner=0, sek_einer=0, counter=60000.
- Run to 99:59.999 (counter=5_999_999), then one tick -> all digits 0, counter 0, running still 1.
- Running, press button again, then 50 ticks -> values frozen. Assert sw0 coincident with a tick -> counter 0 and clear wins. Release sw0, then 5 ticks while running -> counter=5. Set sw7..sw1=1010101 -> led7..led1 match after 3 cycles.
